// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
//
// Scan controller for a multiplexed common-anode 7-segment display.
// Each digit gets a time slot of CLK_DIV cycles. The first BLANK_CYCLES
// cycles of a slot keep every anode off, which stops the previous digit
// from ghosting onto the next one. For the rest of the slot one anode is
// driven low. The active anode rotates left from digit 0 to digit DIGITS-1.
// The segment pattern for the slot is captured once, at the BLANK->SHOW
// edge. Input changes in the middle of a slot therefore cannot tear the
// displayed digit.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   en         in   scanning enable; 0 keeps the display dark
//   digits     in   packed BCD, digit i at [4i+3:4i], digit 0 rightmost
//   dp_mask    in   1 = decimal point lit on digit i
//   blank_lz   in   1 = blank leading zeros (digit 0 never blanked)
//   an         out  anode selects, active-low, at most one bit low
//   seg        out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   digit_idx  out  index of the current slot
//   frame_tick out  one-cycle pulse at the start of each new scan frame
// -----------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [4*DIGITS-1:0]         digits,
    input  logic [DIGITS-1:0]           dp_mask,
    input  logic                        blank_lz,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [$clog2(DIGITS)-1:0]   digit_idx,
    output logic                        frame_tick
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;

    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // BCD to active-low gfedcba. Codes 10-15 are not valid BCD, so they
    // show a dash rather than a misleading hex glyph.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = SEG_DASH;
        endcase
    endfunction

    // Values that are captured at the BLANK->SHOW edge for the current slot.
    logic [3:0]        cur_digit;
    logic              cur_dp;
    logic              cur_lz;
    logic [DIGITS-1:0] an_sel;
    logic              upper_zero;

    // NOTE: every variable gets a default before the loop. Without the
    // defaults, the paths that do not match digit_idx would infer latches.
    always_comb begin
        cur_digit  = 4'd0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        an_sel     = '1;
        upper_zero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                cur_digit = digits[4*i +: 4];
                cur_dp    = dp_mask[i];
                an_sel[i] = 1'b0;
                // A digit is a leading zero only if it and every digit to
                // its left are zero. Digit 0 always shows, so a value of 0
                // still displays "0".
                upper_zero = 1'b1;
                for (int j = i; j < DIGITS; j++) begin
                    if (digits[4*j +: 4] != 4'd0) begin
                        upper_zero = 1'b0;
                    end
                end
                cur_lz = blank_lz && (i != 0) && upper_zero;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        // Reset and disable lead to the same dark IDLE state. Reset has
        // priority simply because both branches are identical.
        if (!rst_n || !en) begin
            state      <= IDLE;
            cnt        <= '0;
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= BLANK;
                    cnt        <= '0;
                    digit_idx  <= '0;
                    an         <= '1;
                    seg        <= SEG_OFF;
                    dp         <= 1'b1;
                    frame_tick <= 1'b0;
                end
                BLANK: begin
                    frame_tick <= 1'b0;
                    cnt        <= cnt + CW'(1);
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        an    <= an_sel;
                        seg   <= cur_lz ? SEG_OFF : decode(cur_digit);
                        dp    <= ~cur_dp;
                    end
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        state      <= BLANK;
                        cnt        <= '0;
                        an         <= '1;
                        seg        <= SEG_OFF;
                        dp         <= 1'b1;
                        digit_idx  <= (digit_idx == LAST_IDX) ? '0 : digit_idx + IW'(1);
                        frame_tick <= (digit_idx == LAST_IDX);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    an    <= '1;
                    seg   <= SEG_OFF;
                    dp    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
//
// Self-checking bench for disp_scan_ctrl with DIGITS=4, CLK_DIV=8 and
// BLANK_CYCLES=2. A table of digit patterns is scanned through one full
// frame, and the BLANK and SHOW outputs of every slot are compared with
// hand-computed values. Hand-written sequences then cover cycle timing,
// frame_tick, mid-slot input changes, en drop and reset mid-slot. A
// monitor checks the anode invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int CLK_DIV = 8;
    localparam int BLANK_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail = 0;
    int k = 0;   // cycles since the IDLE-exit edge (k=1 is the first BLANK cycle)

    disp_scan_ctrl #(
        .DIGITS(DIGITS),
        .CLK_DIV(CLK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .digits(digits),
        .dp_mask(dp_mask),
        .blank_lz(blank_lz),
        .an(an),
        .seg(seg),
        .dp(dp),
        .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dp_mask;
        logic            blank_lz;
        logic [3:0][6:0] seg_exp;  // indexed by slot
        logic [3:0]      dp_exp;   // active-low expected dp, indexed by slot
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s (k=%0d): got %h, expected %h", name, k, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (k < target) begin
            tick();
            k++;
        end
    endtask

    // Reset, idle for a cycle, then enable. This leaves k=1, the first BLANK cycle.
    task automatic start_scan();
        en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        k = 1;
    endtask

    task automatic check_dark(input string name);
        check({name, "_an"}, 32'(an), 32'hF);
        check({name, "_seg"}, 32'(seg), 32'h7F);
        check({name, "_dp"}, 32'(dp), 32'h1);
    endtask

    // Anode invariants on every cycle: at most one low bit, and never a
    // direct change from one low anode to a different low anode.
    logic [3:0] prev_an = 4'hF;
    always @(negedge clk) begin
        check("an_onecold", 32'($countones(~an) <= 1), 32'h1);
        if (prev_an != 4'hF && an != 4'hF) begin
            check("an_no_direct_switch", 32'(an), 32'(prev_an));
        end
        prev_an = an;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          digits    dp_mask  lz    seg {s3,s2,s1,s0}                   dp_exp
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0045, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h12}, 4'b1111};
        vecs[2] = '{16'h0045, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h19, 7'h12}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[4] = '{16'hA000, 4'b0100, 1'b0, {7'h3F, 7'h40, 7'h40, 7'h40}, 4'b1011};
        vecs[5] = '{16'h0900, 4'b1000, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h40}, 4'b0111};
        vecs[6] = '{16'h8765, 4'b0001, 1'b0, {7'h00, 7'h78, 7'h02, 7'h12}, 4'b1110};
        vecs[7] = '{16'hF0B0, 4'b0010, 1'b1, {7'h3F, 7'h40, 7'h3F, 7'h40}, 4'b1101};

        // Reset state
        rst_n = 1'b0;
        tick();
        check_dark("reset");
        check("reset_idx", 32'(digit_idx), 32'h0);
        check("reset_tick", 32'(frame_tick), 32'h0);

        // Table-driven: one full frame per vector
        for (int v = 0; v < 8; v++) begin
            digits = vecs[v].digits;
            dp_mask = vecs[v].dp_mask;
            blank_lz = vecs[v].blank_lz;
            start_scan();
            for (int s = 0; s < DIGITS; s++) begin
                tick_to(8*s + 1);
                check_dark($sformatf("v%0d_s%0d_blank", v, s));
                check($sformatf("v%0d_s%0d_blank_idx", v, s), 32'(digit_idx), 32'(s));
                tick_to(8*s + 3);
                check($sformatf("v%0d_s%0d_an", v, s), 32'(an), 32'(~(4'b0001 << s) & 4'hF));
                check($sformatf("v%0d_s%0d_seg", v, s), 32'(seg), 32'(vecs[v].seg_exp[s]));
                check($sformatf("v%0d_s%0d_dp", v, s), 32'(dp), 32'(vecs[v].dp_exp[s]));
                check($sformatf("v%0d_s%0d_idx", v, s), 32'(digit_idx), 32'(s));
            end
        end

        // Cycle-accurate slot timing and frame_tick across more than a frame
        digits = 16'h1234;
        dp_mask = 4'b0000;
        blank_lz = 1'b0;
        start_scan();
        for (int c = 1; c <= 70; c++) begin
            logic [3:0] exp_an;
            tick_to(c);
            if (((c - 1) % 8) < 2) exp_an = 4'hF;
            else exp_an = ~(4'b0001 << (((c - 1) / 8) % 4));
            check($sformatf("timing_an_k%0d", c), 32'(an), 32'(exp_an));
            check($sformatf("timing_tick_k%0d", c), 32'(frame_tick), 32'(c == 33 || c == 65));
        end

        // Mid-SHOW change of digits has no effect until digit 0 is next latched
        start_scan();
        tick_to(5);
        digits = 16'h1239;
        for (int c = 5; c <= 8; c++) begin
            tick_to(c);
            check($sformatf("midshow_seg_k%0d", c), 32'(seg), 32'h19);
        end
        tick_to(35);
        check("midshow_relatch_an", 32'(an), 32'hE);
        check("midshow_relatch_seg", 32'(seg), 32'h10);

        // en dropped during the SHOW of slot 2, then re-enabled
        digits = 16'h1234;
        start_scan();
        tick_to(20);
        check("endrop_pre_an", 32'(an), 32'hB);
        en = 1'b0;
        tick();
        check_dark("endrop");
        check("endrop_idx", 32'(digit_idx), 32'h0);
        check("endrop_tick", 32'(frame_tick), 32'h0);
        tick();
        tick();
        check_dark("endrop_idle");
        en = 1'b1;
        tick();
        check_dark("reen_k1");
        tick();
        check_dark("reen_k2");
        tick();
        check("reen_an", 32'(an), 32'hE);
        check("reen_seg", 32'(seg), 32'h19);
        check("reen_idx", 32'(digit_idx), 32'h0);

        // Reset for one cycle during the SHOW of slot 1, with en held high
        start_scan();
        tick_to(12);
        check("rstmid_pre_an", 32'(an), 32'hD);
        rst_n = 1'b0;
        tick();
        check_dark("rstmid");
        check("rstmid_idx", 32'(digit_idx), 32'h0);
        rst_n = 1'b1;
        tick();
        check_dark("rstmid_k1");
        tick();
        check_dark("rstmid_k2");
        tick();
        check("rstmid_restart_an", 32'(an), 32'hE);
        check("rstmid_restart_seg", 32'(seg), 32'h19);
        k = 3;
        tick_to(11);
        check("rstmid_slot1_an", 32'(an), 32'hD);
        check("rstmid_slot1_seg", 32'(seg), 32'h30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
